// File: rtl/vx_tcu_drl_fedp_sched.sv
// Round-robin scheduler sharing one DRL FEDP datapath between NUM_REQS requesters.
// Each accepted job issues its K-chunks under credit flow control, then drains before completing.
module vx_tcu_drl_fedp_sched #(
    parameter int NUM_REQS   = 4,
    parameter int MAX_STEPS  = 8,
    parameter int PIPE_DEPTH = 4,
    parameter int SW = $clog2(MAX_STEPS + 1),
    parameter int IW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
    parameter int CW = $clog2(PIPE_DEPTH + 1),
    parameter int RW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQS-1:0]    req_valid,
    output logic [NUM_REQS-1:0]    req_ready,
    input  logic [NUM_REQS*32-1:0] req_id,
    input  logic [NUM_REQS*4-1:0]  req_fmt,
    input  logic [NUM_REQS*SW-1:0] req_steps,
    output logic                   step_valid,
    input  logic                   step_ready,
    output logic [31:0]            step_id,
    output logic [3:0]             step_fmt,
    output logic [RW-1:0]          step_src,
    output logic [IW-1:0]          step_idx,
    output logic                   step_first,
    output logic                   step_last,
    input  logic                   credit_ret,
    output logic                   done_valid,
    output logic [31:0]            done_id,
    output logic [RW-1:0]          done_src,
    output logic                   credit_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    state_t              state_next;
    logic [RW-1:0]       rr_ptr;
    logic [RW-1:0]       next_ptr;
    logic [CW-1:0]       credits;
    logic [SW-1:0]       steps;
    logic [NUM_REQS-1:0] grant;
    logic [RW-1:0]       sel;
    logic                found;
    int                  cand;
    logic [31:0]         sel_id;
    logic [3:0]          sel_fmt;
    logic [SW-1:0]       sel_steps;
    logic [SW-1:0]       clamped_steps;
    logic [SW-1:0]       idx_ext;
    logic                accept;
    logic                fire;
    logic                drained;

    // Search starts at rr_ptr and wraps, so the requester after the last served one wins.
    always_comb begin
        grant = '0;
        sel   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQS) cand = cand - NUM_REQS;
            if (!found && req_valid[RW'(cand)]) begin
                found = 1'b1;
                sel   = RW'(cand);
            end
        end
        if (found) grant[sel] = 1'b1;
    end

    always_comb begin
        sel_id    = '0;
        sel_fmt   = '0;
        sel_steps = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (sel == RW'(i)) begin
                sel_id    = req_id[i*32 +: 32];
                sel_fmt   = req_fmt[i*4 +: 4];
                sel_steps = req_steps[i*SW +: SW];
            end
        end
    end

    assign clamped_steps = (sel_steps > SW'(MAX_STEPS)) ? SW'(MAX_STEPS) : sel_steps;
    assign req_ready     = (state == IDLE && reset_n) ? grant : '0;
    assign accept        = |(req_valid & req_ready);
    assign step_valid    = (state == ISSUE) && (credits != '0);
    assign fire          = step_valid && step_ready;
    assign idx_ext       = SW'(step_idx);
    assign step_first    = (state == ISSUE) && (step_idx == '0);
    assign step_last     = (state == ISSUE) && (idx_ext == steps - SW'(1));
    assign drained       = (state == DRAIN) && (credits == CW'(PIPE_DEPTH));
    assign next_ptr      = (int'(step_src) == NUM_REQS - 1) ? '0 : step_src + RW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (clamped_steps != '0) ? ISSUE : DRAIN;
            ISSUE:   if (fire && step_last) state_next = DRAIN;
            DRAIN:   if (drained) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            credits    <= CW'(PIPE_DEPTH);
            steps      <= '0;
            step_id    <= '0;
            step_fmt   <= '0;
            step_src   <= '0;
            step_idx   <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_src   <= '0;
            credit_err <= 1'b0;
        end else begin
            done_valid <= drained;
            if (accept) begin
                step_id  <= sel_id;
                step_fmt <= sel_fmt;
                step_src <= sel;
                steps    <= clamped_steps;
                step_idx <= '0;
            end else if (fire) begin
                step_idx <= step_idx + IW'(1);
            end
            if (drained) begin
                done_id  <= step_id;
                done_src <= step_src;
                rr_ptr   <= next_ptr;
            end
            // A return that would overflow a full counter is dropped and flagged.
            if (fire && !credit_ret) begin
                credits <= credits - CW'(1);
            end else if (!fire && credit_ret) begin
                if (credits == CW'(PIPE_DEPTH)) credit_err <= 1'b1;
                else                            credits    <= credits + CW'(1);
            end
        end
    end
endmodule
